// File: rtl/err_arb_pkg.sv
// err_arb_pkg: shared sizes and the log record type for the error event arbiter
package err_arb_pkg;
  localparam int N_SRC = 4;
  localparam int ID_W = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int SRC_W = $clog2(N_SRC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [ID_W-1:0]  id;
  } err_rec_t;
endpackage

// File: rtl/error_event_arbiter_fifo.sv
// err_log_fifo: synchronous log buffer of error records with same-cycle push and pop
module err_log_fifo
  import err_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  err_rec_t din,
  output err_rec_t dout,
  output logic     full,
  output logic     empty
);
  err_rec_t mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0] cnt_q, cnt_d;
  assign full = cnt_q == (PTR_W+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];
  // pointers wrap naturally because the depth is a power of two
  always_comb begin
    wr_d = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d = pop ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage is not reset; occupancy decides what is visible
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/error_event_arbiter.sv
// error_event_arbiter: round-robin serialiser of error events into a log FIFO with count/first/last capture
module error_event_arbiter
  import err_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      i_err_valid,
  input  logic [N_SRC*ID_W-1:0] i_err_id,
  output logic [N_SRC-1:0]      o_err_ready,
  output logic                  o_log_valid,
  output logic [SRC_W-1:0]      o_log_src,
  output logic [ID_W-1:0]       o_log_id,
  input  logic                  i_log_ready,
  input  logic                  i_clear,
  output logic [CNT_W-1:0]      o_err_count,
  output logic                  o_first_valid,
  output logic [ID_W-1:0]       o_first_id,
  output logic [ID_W-1:0]       o_last_id,
  output logic                  o_saturated
);
  logic [SRC_W-1:0] ptr_q, ptr_d, gnt;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
  logic [ID_W-1:0] first_id_q, first_id_d, last_id_q, last_id_d, acc_id;
  logic first_valid_q, first_valid_d, sat_q, sat_d, base_fv, base_sat;
  logic found, accept, pop, full, empty;
  err_rec_t head;
  // scan from ptr downwards-last so the lowest offset from ptr wins
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_err_valid[(int'(ptr_q) + i) % N_SRC]) begin
        found = 1'b1;
        gnt = SRC_W'((int'(ptr_q) + i) % N_SRC);
      end
    end
  end
  assign pop = !empty & i_log_ready;
  assign accept = found & (!full | pop) & !rst;
  assign acc_id = i_err_id[int'(gnt)*ID_W +: ID_W];
  assign o_err_ready = accept ? {{(N_SRC-1){1'b0}}, 1'b1} << gnt : '0;
  // clear applies first so a same-cycle accept lands on the cleared state
  always_comb begin
    base_cnt = i_clear ? '0 : cnt_q;
    base_fv = i_clear ? 1'b0 : first_valid_q;
    base_sat = i_clear ? 1'b0 : sat_q;
    cnt_d = accept && !(&base_cnt) ? base_cnt + CNT_W'(1) : base_cnt;
    sat_d = base_sat | (accept & (&base_cnt));
    first_valid_d = base_fv | accept;
    first_id_d = accept && !base_fv ? acc_id : first_id_q;
    last_id_d = accept ? acc_id : last_id_q;
    ptr_d = !accept ? ptr_q : int'(gnt) == N_SRC - 1 ? '0 : gnt + SRC_W'(1);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      first_valid_q <= 1'b0;
      first_id_q <= '0;
      last_id_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      first_valid_q <= first_valid_d;
      first_id_q <= first_id_d;
      last_id_q <= last_id_d;
    end
  end
  err_log_fifo u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .pop  (pop),
    .din  ('{src: gnt, id: acc_id}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign o_log_valid = !empty;
  assign o_log_src = head.src;
  assign o_log_id = head.id;
  assign o_err_count = cnt_q;
  assign o_first_valid = first_valid_q;
  assign o_first_id = first_id_q;
  assign o_last_id = last_id_q;
  assign o_saturated = sat_q;
endmodule

// File: tb/tb_error_event_arbiter.sv
// tb_error_event_arbiter: scoreboard bench with a queue-based reference model of the arbiter
module tb_error_event_arbiter;
  localparam int CNT_MAX = 15;
  typedef struct {int src; int id;} rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] i_err_valid = '0;
  logic [31:0] i_err_id = '0;
  logic [3:0] o_err_ready;
  logic o_log_valid;
  logic [1:0] o_log_src;
  logic [7:0] o_log_id;
  logic i_log_ready = 1'b0;
  logic i_clear = 1'b0;
  logic [3:0] o_err_count;
  logic o_first_valid;
  logic [7:0] o_first_id;
  logic [7:0] o_last_id;
  logic o_saturated;
  int checks = 0;
  int errors = 0;
  rec_t sb[$];
  bit held[4];
  logic [7:0] hid[4];
  int ptr = 0, occ = 0, cnt = 0;
  bit sat = 0, fv = 0;
  logic [7:0] fid = '0, lid = '0;
  error_event_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .i_err_valid(i_err_valid), .i_err_id(i_err_id),
    .o_err_ready(o_err_ready), .o_log_valid(o_log_valid), .o_log_src(o_log_src),
    .o_log_id(o_log_id), .i_log_ready(i_log_ready), .i_clear(i_clear),
    .o_err_count(o_err_count), .o_first_valid(o_first_valid), .o_first_id(o_first_id),
    .o_last_id(o_last_id), .o_saturated(o_saturated)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic hold(input int s, input logic [7:0] id);
    held[s] = 1'b1;
    hid[s] = id;
  endtask
  // one clock: drive inputs after the edge, then check and advance the model mid-cycle
  task automatic step(input bit rdy, input bit clr, input bit r);
    bit acc, pop_m;
    int s_exp;
    @(posedge clk);
    #1;
    rst = r;
    i_log_ready = rdy;
    i_clear = clr;
    for (int s = 0; s < 4; s++) begin
      i_err_valid[s] = held[s];
      i_err_id[s*8 +: 8] = hid[s];
    end
    @(negedge clk);
    chk("log_valid", o_log_valid, 32'(occ > 0));
    chk("count", o_err_count, cnt);
    chk("saturated", o_saturated, sat);
    chk("first_valid", o_first_valid, fv);
    if (fv) chk("first_id", o_first_id, fid);
    chk("last_id", o_last_id, lid);
    pop_m = occ > 0 && rdy;
    acc = 1'b0;
    s_exp = 0;
    if (!r && (occ < 4 || pop_m))
      for (int i = 0; i < 4; i++)
        if (!acc && held[(ptr + i) % 4]) begin
          acc = 1'b1;
          s_exp = (ptr + i) % 4;
        end
    chk("grant", o_err_ready, acc ? 32'(1) << s_exp : 32'd0);
    if (r) begin
      occ = 0; ptr = 0; cnt = 0; sat = 0; fv = 0; fid = '0; lid = '0;
      sb.delete();
    end else begin
      occ += int'(acc) - int'(pop_m);
      if (clr) begin cnt = 0; fv = 0; sat = 0; end
      if (acc) begin
        sb.push_back('{s_exp, int'(hid[s_exp])});
        lid = hid[s_exp];
        if (cnt == CNT_MAX) sat = 1; else cnt++;
        if (!fv) begin fv = 1; fid = hid[s_exp]; end
        held[s_exp] = 1'b0;
        ptr = (s_exp + 1) % 4;
      end
    end
  endtask
  // monitor: every record the sink takes must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && o_log_valid && i_log_ready) begin
      if (sb.size() == 0) chk("log_unexpected", 32'(o_log_id), 32'hFFFF_FFFF);
      else begin
        rec_t e;
        e = sb.pop_front();
        chk("log_src", o_log_src, e.src);
        chk("log_id", o_log_id, e.id);
      end
    end
  end
  initial begin
    for (int s = 0; s < 4; s++) begin held[s] = 1'b0; hid[s] = '0; end
    repeat (2) @(posedge clk);
    step(0, 0, 0);
    chk("reset_count", o_err_count, 0);
    chk("reset_log_valid", o_log_valid, 0);
    // all four sources at once: round-robin 0..3
    for (int s = 0; s < 4; s++) hold(s, 8'(10 + s));
    repeat (4) step(1, 0, 0);
    repeat (6) step(1, 0, 0);
    chk("t1_count", o_err_count, 4);
    chk("t1_first", o_first_id, 10);
    chk("t1_last", o_last_id, 13);
    // stalled sink with source 2 always requesting, then release
    for (int k = 0; k < 6; k++) begin
      if (!held[2]) hold(2, 8'(8'h20 + k));
      step(0, 0, 0);
    end
    chk("t2_stalled_ready", o_err_ready, 0);
    for (int k = 0; k < 6; k++) begin
      if (!held[2]) hold(2, 8'(8'h30 + k));
      step(1, 0, 0);
    end
    repeat (6) step(1, 0, 0);
    // saturation then clear
    step(1, 1, 0);
    for (int k = 0; k < 17; k++) begin
      hold(0, 8'(8'h40 + k));
      step(1, 0, 0);
    end
    step(1, 0, 0);
    chk("t3_count_max", o_err_count, 15);
    chk("t3_saturated", o_saturated, 1);
    step(1, 1, 0);
    step(1, 0, 0);
    chk("t3_clr_count", o_err_count, 0);
    chk("t3_clr_sat", o_saturated, 0);
    chk("t3_clr_fv", o_first_valid, 0);
    // clear coinciding with an accept
    repeat (4) step(1, 0, 0);
    hold(3, 8'h55);
    step(1, 1, 0);
    step(1, 0, 0);
    chk("t4_count", o_err_count, 1);
    chk("t4_first", o_first_id, 8'h55);
    chk("t4_fv", o_first_valid, 1);
    // full FIFO, pop and new request together
    repeat (4) step(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      hold(0, 8'(8'h60 + k));
      step(0, 0, 0);
    end
    hold(1, 8'h77);
    step(1, 0, 0);
    chk("t5_grant_src1", o_err_ready, 4'b0010);
    step(0, 0, 0);
    chk("t5_still_full", o_err_ready, 0);
    repeat (8) step(1, 0, 0);
    // reset with records buffered and requests in flight
    for (int k = 0; k < 3; k++) begin
      hold(2, 8'(8'h80 + k));
      step(0, 0, 0);
    end
    hold(1, 8'h91);
    hold(3, 8'h93);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t6_log_valid", o_log_valid, 0);
    chk("t6_count", o_err_count, 0);
    chk("t6_grant", o_err_ready, 4'b0010);
    repeat (4) step(1, 0, 0);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int s = 0; s < 4; s++)
        if (!held[s] && $urandom_range(0, 2) == 0) hold(s, 8'($urandom));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (10) step(1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
